// File: rtl/spram_arb_pkg.sv
// Shared types and helpers for the single-port RAM arbiter.
// Read tags carry a fixed-width ID so any requester count up to 16 fits.
package spram_arb_pkg;

    localparam int CNT_W    = 16;
    localparam int MAX_ID_W = 4;

    typedef struct packed {
        logic                valid;
        logic [MAX_ID_W-1:0] id;
    } rd_tag_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value, input logic en);
        return (en && (value != {CNT_W{1'b1}})) ? value + CNT_W'(1) : value;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first asserted request at or after ptr,
// wrapping modulo N. Returns both a one-hot grant and the granted index.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] grant_idx,
    output logic                 grant_valid
);

    localparam int IW = $clog2(N);

    logic [IW:0]   sum;
    logic [IW-1:0] idx;

    // Walk offsets from farthest to nearest so the candidate closest to ptr is written last.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        sum         = '0;
        idx         = '0;
        for (int k = N - 1; k >= 0; k--) begin
            sum = {1'b0, ptr} + (IW+1)'(k);
            idx = (sum >= (IW+1)'(N)) ? IW'(sum - (IW+1)'(N)) : IW'(sum);
            if (req[idx]) begin
                grant_valid = 1'b1;
                grant_idx   = idx;
            end
        end
        grant = grant_valid ? (N'(1) << grant_idx) : '0;
    end

endmodule

// File: rtl/spram_arbiter.sv
// Round-robin sharing of one single-port RAM among N_REQ requesters, with a registered
// command stage, a fixed-latency read tag pipeline and saturating ECC event counters.
module spram_arbiter
    import spram_arb_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int RD_LATENCY = 1,
    localparam int ID_W      = $clog2(N_REQ)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_REQ-1:0]              req_valid,
    output logic [N_REQ-1:0]              req_ready,
    input  logic [N_REQ-1:0]              req_we,
    input  logic [N_REQ*ADDR_WIDTH-1:0]   req_addr,
    input  logic [N_REQ*DATA_WIDTH-1:0]   req_wdata,
    output logic                          mem_cs,
    output logic                          mem_we,
    output logic [ADDR_WIDTH-1:0]         mem_addr,
    output logic [DATA_WIDTH-1:0]         mem_wdata,
    input  logic [DATA_WIDTH-1:0]         mem_rdata,
    input  logic                          mem_ecccorr,
    input  logic                          mem_eccderr,
    output logic                          rsp_valid,
    output logic [ID_W-1:0]               rsp_id,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic                          rsp_ecccorr,
    output logic                          rsp_eccderr,
    output logic [CNT_W-1:0]              corr_cnt,
    output logic [CNT_W-1:0]              derr_cnt
);

    logic [N_REQ-1:0]      grant;
    logic [ID_W-1:0]       grant_idx;
    logic                  grant_valid;

    logic [ID_W-1:0]       ptr_q, ptr_d;
    logic                  mem_cs_q, mem_cs_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic [ID_W-1:0]       mem_id_q, mem_id_d;
    rd_tag_t               tag_q [RD_LATENCY+1];
    rd_tag_t               tag_d [RD_LATENCY+1];
    logic [CNT_W-1:0]      corr_cnt_q, corr_cnt_d;
    logic [CNT_W-1:0]      derr_cnt_q, derr_cnt_d;

    rr_arbiter #(
        .N(N_REQ)
    ) u_rr (
        .req         (req_valid),
        .ptr         (ptr_q),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    assign req_ready = rst ? '0 : grant;

    always_comb begin
        ptr_d       = ptr_q;
        mem_cs_d    = grant_valid;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_id_d    = mem_id_q;
        if (grant_valid) begin
            ptr_d       = (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
            mem_we_d    = req_we[grant_idx];
            mem_addr_d  = req_addr[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
            mem_wdata_d = req_wdata[grant_idx*DATA_WIDTH +: DATA_WIDTH];
            mem_id_d    = grant_idx;
        end

        // The tag enters on the RAM sample edge, so its tail lines up with rd_data.
        tag_d[0] = '{valid: mem_cs_q & ~mem_we_q, id: MAX_ID_W'(mem_id_q)};
        for (int k = 1; k <= RD_LATENCY; k++) begin
            tag_d[k] = tag_q[k-1];
        end

        corr_cnt_d = sat_inc(corr_cnt_q, rsp_valid & mem_ecccorr);
        derr_cnt_d = sat_inc(derr_cnt_q, rsp_valid & mem_eccderr);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q       <= '0;
            mem_cs_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_id_q    <= '0;
            for (int k = 0; k <= RD_LATENCY; k++) begin
                tag_q[k] <= '0;
            end
            corr_cnt_q  <= '0;
            derr_cnt_q  <= '0;
        end else begin
            ptr_q       <= ptr_d;
            mem_cs_q    <= mem_cs_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_id_q    <= mem_id_d;
            for (int k = 0; k <= RD_LATENCY; k++) begin
                tag_q[k] <= tag_d[k];
            end
            corr_cnt_q  <= corr_cnt_d;
            derr_cnt_q  <= derr_cnt_d;
        end
    end

    assign mem_cs      = mem_cs_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign rsp_valid   = tag_q[RD_LATENCY].valid;
    assign rsp_id      = tag_q[RD_LATENCY].id[ID_W-1:0];
    assign rsp_data    = mem_rdata;
    assign rsp_ecccorr = mem_ecccorr;
    assign rsp_eccderr = mem_eccderr;
    assign corr_cnt    = corr_cnt_q;
    assign derr_cnt    = derr_cnt_q;

endmodule

// File: tb/tb_spram_arbiter.sv
// Bench for spram_arbiter: two instances (read latency 1 and 3) share stimulus and a RAM
// model; a transaction-level reference predicts grants, commands, responses and counters.
module tb_spram_arbiter;

    localparam int N  = 4;
    localparam int AW = 8;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_we    = '0;
    logic [N*AW-1:0] req_addr  = '0;
    logic [N*DW-1:0] req_wdata = '0;

    logic [N-1:0]    rdy   [2];
    logic            cs    [2];
    logic            we    [2];
    logic [AW-1:0]   maddr [2];
    logic [DW-1:0]   mwd   [2];
    logic [DW-1:0]   mrd   [2];
    logic            mcorr [2];
    logic            mderr [2];
    logic            rv    [2];
    logic [1:0]      rid   [2];
    logic [DW-1:0]   rdat  [2];
    logic            rcorr [2];
    logic            rderr [2];
    logic [15:0]     ccnt  [2];
    logic [15:0]     dcnt  [2];

    spram_arbiter #(.N_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(1)) u_dut1 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy[0]), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .mem_cs(cs[0]), .mem_we(we[0]),
        .mem_addr(maddr[0]), .mem_wdata(mwd[0]), .mem_rdata(mrd[0]), .mem_ecccorr(mcorr[0]),
        .mem_eccderr(mderr[0]), .rsp_valid(rv[0]), .rsp_id(rid[0]), .rsp_data(rdat[0]),
        .rsp_ecccorr(rcorr[0]), .rsp_eccderr(rderr[0]), .corr_cnt(ccnt[0]), .derr_cnt(dcnt[0])
    );

    spram_arbiter #(.N_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(3)) u_dut3 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy[1]), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .mem_cs(cs[1]), .mem_we(we[1]),
        .mem_addr(maddr[1]), .mem_wdata(mwd[1]), .mem_rdata(mrd[1]), .mem_ecccorr(mcorr[1]),
        .mem_eccderr(mderr[1]), .rsp_valid(rv[1]), .rsp_id(rid[1]), .rsp_data(rdat[1]),
        .rsp_ecccorr(rcorr[1]), .rsp_eccderr(rderr[1]), .corr_cnt(ccnt[1]), .derr_cnt(dcnt[1])
    );

    // RAM model: samples on the edge where cs is seen, data appears RD_LATENCY edges later.
    // Non-read slots return junk with both ECC flags set.
    logic [DW-1:0]   ram      [256];
    logic            corr_mem [256];
    logic            derr_mem [256];
    logic [DW+1:0]   pipe1    [2];
    logic [DW+1:0]   pipe3    [4];

    always @(posedge clk) begin
        if (cs[0] && we[0]) ram[maddr[0]] <= mwd[0];
        pipe1[0] <= (cs[0] && !we[0]) ? {corr_mem[maddr[0]], derr_mem[maddr[0]], ram[maddr[0]]}
                                      : {2'b11, DW'($urandom)};
        pipe1[1] <= pipe1[0];
        pipe3[0] <= (cs[1] && !we[1]) ? {corr_mem[maddr[1]], derr_mem[maddr[1]], ram[maddr[1]]}
                                      : {2'b11, DW'($urandom)};
        for (int k = 1; k < 4; k++) pipe3[k] <= pipe3[k-1];
    end

    always_comb begin
        {mcorr[0], mderr[0], mrd[0]} = pipe1[1];
        {mcorr[1], mderr[1], mrd[1]} = pipe3[3];
    end

    // Reference model state
    typedef struct {
        int          edge_no;
        logic [1:0]  id;
        logic [DW-1:0] data;
        logic        corr;
        logic        derr;
    } exp_rsp_t;

    exp_rsp_t      exp_q [$];
    int            head [2];
    int            ref_ccnt [2];
    int            ref_dcnt [2];
    logic [DW-1:0] ref_mem [256];
    int            ref_ptr;
    logic          exp_cs, exp_we;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_wdata;

    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    bit   quiet = 0;
    logic [1:0]    last_id;
    logic [DW-1:0] last_data;
    int   last_cyc;

    function automatic int lat(input int u);
        return (u == 0) ? 1 : 3;
    endfunction

    task automatic check(input string name, input int u, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (lat%0d) cycle %0d: got %h, expected %h", name, lat(u), cyc, act, exp);
        end
    endtask

    task automatic check_outputs();
        exp_rsp_t e;
        for (int u = 0; u < 2; u++) begin
            check("mem_cs", u, 32'(cs[u]), 32'(exp_cs));
            check("mem_we", u, 32'(we[u]), 32'(exp_we));
            check("mem_addr", u, 32'(maddr[u]), 32'(exp_addr));
            check("mem_wdata", u, 32'(mwd[u]), 32'(exp_wdata));
            check("corr_cnt", u, 32'(ccnt[u]), ref_ccnt[u]);
            check("derr_cnt", u, 32'(dcnt[u]), ref_dcnt[u]);
            if (head[u] < exp_q.size() && exp_q[head[u]].edge_no + lat(u) + 1 == cyc) begin
                e = exp_q[head[u]];
                head[u]++;
                check("rsp_valid", u, 32'(rv[u]), 1);
                check("rsp_id", u, 32'(rid[u]), 32'(e.id));
                check("rsp_data", u, 32'(rdat[u]), 32'(e.data));
                check("rsp_ecccorr", u, 32'(rcorr[u]), 32'(e.corr));
                check("rsp_eccderr", u, 32'(rderr[u]), 32'(e.derr));
                if (e.corr && ref_ccnt[u] < 65535) ref_ccnt[u]++;
                if (e.derr && ref_dcnt[u] < 65535) ref_dcnt[u]++;
                if (!quiet)
                    $display("cycle %0d: lat%0d response id=%0d data=%h corr=%0d derr=%0d",
                             cyc, lat(u), e.id, e.data, e.corr, e.derr);
            end else begin
                check("rsp_valid", u, 32'(rv[u]), 0);
            end
            if (u == 0 && rv[0] === 1'b1) begin
                last_id   = rid[0];
                last_data = rdat[0];
                last_cyc  = cyc;
            end
        end
    endtask

    // One clock of stimulus; entered and left just after a falling edge.
    task automatic step(input logic [N-1:0] v, input logic [N-1:0] w, input logic [N*AW-1:0] a,
                        input logic [N*DW-1:0] d, input bit use_exp, input logic [N-1:0] exp_rdy);
        int g;
        logic [N-1:0] mdl_rdy;
        req_valid = v;
        req_we    = w;
        req_addr  = a;
        req_wdata = d;
        #1;
        g = -1;
        for (int k = 0; k < N && g < 0; k++)
            if (v[(ref_ptr + k) % N]) g = (ref_ptr + k) % N;
        mdl_rdy = (g >= 0) ? (N'(1) << g) : '0;
        for (int u = 0; u < 2; u++) check("req_ready", u, 32'(rdy[u]), 32'(mdl_rdy));
        if (use_exp) check("table_ready", 0, 32'(rdy[0]), 32'(exp_rdy));
        @(posedge clk);
        cyc++;
        exp_cs = (g >= 0);
        if (g >= 0) begin
            ref_ptr   = (g + 1) % N;
            exp_we    = w[g];
            exp_addr  = a[g*AW +: AW];
            exp_wdata = d[g*DW +: DW];
            if (exp_we) ref_mem[exp_addr] = exp_wdata;
            else exp_q.push_back('{cyc, 2'(g), ref_mem[exp_addr], corr_mem[exp_addr], derr_mem[exp_addr]});
            if (!quiet)
                $display("cycle %0d: grant req%0d %s addr=%h data=%h", cyc, g,
                         exp_we ? "write" : "read ", exp_addr, exp_we ? exp_wdata : ref_mem[exp_addr]);
        end
        @(negedge clk);
        check_outputs();
    endtask

    task automatic do_reset();
        req_valid = '1;
        req_we    = '0;
        rst = 1'b1;
        #1;
        for (int u = 0; u < 2; u++) begin
            check("ready_in_reset", u, 32'(rdy[u]), 0);
            check("cs_async_reset", u, 32'(cs[u]), 0);
            check("rsp_async_reset", u, 32'(rv[u]), 0);
        end
        repeat (2) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            for (int u = 0; u < 2; u++) begin
                check("ready_in_reset", u, 32'(rdy[u]), 0);
                check("reset_mem_cs", u, 32'(cs[u]), 0);
                check("reset_mem_we", u, 32'(we[u]), 0);
                check("reset_mem_addr", u, 32'(maddr[u]), 0);
                check("reset_mem_wdata", u, 32'(mwd[u]), 0);
                check("reset_rsp_valid", u, 32'(rv[u]), 0);
                check("reset_corr_cnt", u, 32'(ccnt[u]), 0);
                check("reset_derr_cnt", u, 32'(dcnt[u]), 0);
            end
        end
        rst = 1'b0;
        req_valid = '0;
        ref_ptr = 0;
        exp_cs = 0; exp_we = 0; exp_addr = '0; exp_wdata = '0;
        for (int u = 0; u < 2; u++) begin
            ref_ccnt[u] = 0;
            ref_dcnt[u] = 0;
            head[u] = exp_q.size();
        end
        $display("cycle %0d: reset applied", cyc);
    endtask

    typedef struct {
        bit         pre_rst;
        logic [3:0] valid;
        logic [3:0] we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0] exp_ready;
    } vec_t;

    vec_t tbl [18];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N*AW-1:0] ra;
        logic [N*DW-1:0] rd;
        logic [8:0]      l3_pat;
        int              row1_cyc;

        for (int i = 0; i < 256; i++) begin
            corr_mem[i] = 1'b0;
            derr_mem[i] = 1'b0;
            ref_mem[i]  = '0;
        end
        head[0] = 0; head[1] = 0;
        last_cyc = -100; last_id = '0; last_data = '0; row1_cyc = 0;

        //            rst   valid    we       addr          wdata         ready
        tbl[0]  = '{1'b0, 4'b0010, 4'b0010, 32'h0000_1000, 32'h0000_A500, 4'b0010};
        tbl[1]  = '{1'b0, 4'b0010, 4'b0000, 32'h0000_1000, 32'h0,         4'b0010};
        tbl[2]  = '{1'b0, 4'b0000, 4'b0000, 32'h0,         32'h0,         4'b0000};
        tbl[3]  = '{1'b0, 4'b0000, 4'b0000, 32'h0,         32'h0,         4'b0000};
        tbl[4]  = '{1'b1, 4'b1111, 4'b0000, 32'h0706_0504, 32'h0,         4'b0001};
        tbl[5]  = '{1'b0, 4'b1111, 4'b0000, 32'h0706_0504, 32'h0,         4'b0010};
        tbl[6]  = '{1'b0, 4'b1111, 4'b0000, 32'h0706_0504, 32'h0,         4'b0100};
        tbl[7]  = '{1'b0, 4'b1111, 4'b0000, 32'h0706_0504, 32'h0,         4'b1000};
        tbl[8]  = '{1'b0, 4'b1111, 4'b0000, 32'h0b0a_0908, 32'h0,         4'b0001};
        tbl[9]  = '{1'b0, 4'b1111, 4'b0000, 32'h0b0a_0908, 32'h0,         4'b0010};
        tbl[10] = '{1'b0, 4'b1111, 4'b0000, 32'h0b0a_0908, 32'h0,         4'b0100};
        tbl[11] = '{1'b0, 4'b1111, 4'b0000, 32'h0b0a_0908, 32'h0,         4'b1000};
        tbl[12] = '{1'b0, 4'b0100, 4'b0000, 32'h0011_2233, 32'h0,         4'b0100};
        tbl[13] = '{1'b0, 4'b1001, 4'b0000, 32'h0c00_000d, 32'h0,         4'b1000};
        tbl[14] = '{1'b0, 4'b1001, 4'b0000, 32'h0e00_000f, 32'h0,         4'b0001};
        tbl[15] = '{1'b0, 4'b1001, 4'b0000, 32'h1200_0013, 32'h0,         4'b1000};
        tbl[16] = '{1'b0, 4'b0000, 4'b0000, 32'h0,         32'h0,         4'b0000};
        tbl[17] = '{1'b0, 4'b0000, 4'b0000, 32'h0,         32'h0,         4'b0000};

        @(negedge clk);
        do_reset();

        // Preload addresses 0..63, rotating across requesters
        for (int k = 0; k < 64; k++)
            step(N'(1) << (k % N), N'(1) << (k % N), {N{AW'(k)}}, {N{DW'(k*5 + 1)}}, 1'b0, '0);

        for (int r = 0; r < 18; r++) begin
            if (tbl[r].pre_rst) do_reset();
            step(tbl[r].valid, tbl[r].we, tbl[r].addr, tbl[r].wdata, 1'b1, tbl[r].exp_ready);
            if (r == 1) row1_cyc = cyc;
            if (r == 3) begin
                check("single_read_id", 0, 32'(last_id), 1);
                check("single_read_data", 0, 32'(last_data), 32'hA5);
                check("single_read_latency", 0, last_cyc - row1_cyc, 2);
            end
        end

        // Random traffic with random ECC flags
        for (int i = 0; i < 64; i++) begin
            corr_mem[i] = ($urandom_range(0, 3) == 0);
            derr_mem[i] = ($urandom_range(0, 5) == 0);
        end
        for (int t = 0; t < 400; t++) begin
            for (int i = 0; i < N; i++) begin
                ra[i*AW +: AW] = AW'($urandom_range(0, 63));
                rd[i*DW +: DW] = DW'($urandom);
            end
            step(N'($urandom), N'($urandom), ra, rd, 1'b0, '0);
        end
        repeat (5) step('0, '0, '0, '0, 1'b0, '0);

        // ECC counting: three corrected, one uncorrectable
        do_reset();
        for (int i = 0; i < 256; i++) begin
            corr_mem[i] = 1'b0;
            derr_mem[i] = 1'b0;
        end
        corr_mem[8'h20] = 1'b1; corr_mem[8'h21] = 1'b1; corr_mem[8'h22] = 1'b1;
        derr_mem[8'h23] = 1'b1;
        for (int k = 0; k < 4; k++)
            step(4'b0001, 4'b0000, {24'h0, 8'h20 + 8'(k)}, '0, 1'b1, 4'b0001);
        repeat (6) step('0, '0, '0, '0, 1'b0, '0);
        for (int u = 0; u < 2; u++) begin
            check("ecc_corr_total", u, 32'(ccnt[u]), 3);
            check("ecc_derr_total", u, 32'(dcnt[u]), 1);
        end

        // Saturation of the correction counter
        corr_mem[8'h30] = 1'b1;
        quiet = 1;
        $display("cycle %0d: streaming 65540 corrected reads", cyc);
        for (int k = 0; k < 65540; k++)
            step(4'b0001, 4'b0000, {24'h0, 8'h30}, '0, 1'b0, '0);
        repeat (6) step('0, '0, '0, '0, 1'b0, '0);
        quiet = 0;
        for (int u = 0; u < 2; u++) check("corr_cnt_saturated", u, 32'(ccnt[u]), 32'hFFFF);

        // Latency-3 instance: back-to-back reads from requesters 0,1,2
        do_reset();
        l3_pat = 9'b0_0111_0000;
        for (int j = 0; j < 9; j++) begin
            case (j)
                0:       step(4'b0111, 4'b0000, 32'h0003_0201, '0, 1'b1, 4'b0001);
                1:       step(4'b0110, 4'b0000, 32'h0003_0201, '0, 1'b1, 4'b0010);
                2:       step(4'b0100, 4'b0000, 32'h0003_0201, '0, 1'b1, 4'b0100);
                default: step(4'b0000, 4'b0000, '0, '0, 1'b1, 4'b0000);
            endcase
            check("lat3_rsp_valid", 1, 32'(rv[1]), 32'(l3_pat[j]));
            if (l3_pat[j]) check("lat3_rsp_id", 1, 32'(rid[1]), j - 4);
        end

        // Reset with two reads in flight
        step(4'b0011, 4'b0000, 32'h0000_0504, '0, 1'b1, 4'b0001);
        step(4'b0010, 4'b0000, 32'h0000_0504, '0, 1'b1, 4'b0010);
        do_reset();
        repeat (6) step('0, '0, '0, '0, 1'b0, '0);
        step(4'b1010, 4'b0000, 32'h0900_0800, '0, 1'b1, 4'b0010);
        repeat (6) step('0, '0, '0, '0, 1'b0, '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/spram_arbiter.md
# spram_arbiter

Round-robin arbiter that shares one single-port RAM (the `spram_model` memory interface: cs/we/addr/wr_data in, rd_data/ecccorr/eccderr out) among N requesters. It grants at most one access per cycle and drives registered memory commands. It tracks outstanding reads through a fixed-latency tag pipeline and returns each read result with the originating requester ID. It sits between the requester agents and the RAM model in the memory-interface checker bench.

## Interface
- `N_REQ`, 4: number of requesters, 2..16.
- `ADDR_WIDTH`, 8: RAM address width.
- `DATA_WIDTH`, 8: RAM data width.
- `RD_LATENCY`, 1: RAM read latency in cycles, from sample edge to `rd_data` valid; ≥1; must match the RAM setting.
- `ID_W`, `$clog2(N_REQ)`: requester ID width (localparam).

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset; asynchronous, active-high.
- `req_valid` in N_REQ: per-requester request.
- `req_ready` out N_REQ: one-hot grant; a transfer occurs when valid&ready.
- `req_we` in N_REQ: 1=write, 0=read.
- `req_addr` in N_REQ*ADDR_WIDTH: packed addresses; requester i at slice i.
- `req_wdata` in N_REQ*DATA_WIDTH: packed write data.
- `mem_cs`, `mem_we` out 1: RAM chip select and write enable.
- `mem_addr` out ADDR_WIDTH, `mem_wdata` out DATA_WIDTH: RAM command.
- `mem_rdata` in DATA_WIDTH, `mem_ecccorr` in 1, `mem_eccderr` in 1: RAM read return.
- `rsp_valid` out 1, `rsp_id` out ID_W, `rsp_data` out DATA_WIDTH, `rsp_ecccorr` out 1, `rsp_eccderr` out 1: read response; no backpressure.
- `corr_cnt`, `derr_cnt` out 16: saturating counts of responses carrying ecccorr / eccderr.

## Operation
- Arbitration (combinational): priority pointer `ptr`. Grant goes to the first requester with valid set, scanning ptr, ptr+1, … with mod-N_REQ wrap.
  - `req_ready` depends on `req_valid`; requesters must not wait for ready before asserting valid.
  - No valid asserted: no grant, and `ptr` holds.
- On a grant to requester i, `ptr` ← (i+1) mod N_REQ at the clock edge. This gives starvation freedom: any continuously valid requester is granted within N_REQ cycles.
- Accepted command registered into `mem_*`. `mem_cs`=1 for exactly one cycle per grant. When there is no grant, `mem_cs`=0 and `mem_addr`/`mem_wdata`/`mem_we` hold their last values.
- Reads: tag {valid, id} enters a shift pipeline of depth RD_LATENCY+1.
  - At the pipeline tail, `rsp_valid`=1 and `rsp_id`=tag id.
  - `rsp_data`/`rsp_ecccorr`/`rsp_eccderr` are passed combinationally from `mem_*`. X data from unwritten addresses is passed through unmodified.
- Writes produce no response.
- Counters increment on `rsp_valid & rsp_ecccorr` (resp. `eccderr`) and saturate at 16'hFFFF.
- Back-to-back reads are fully pipelined: one response per cycle at most.

## Timing
- Reset values:
  - `ptr`=0.
  - `mem_cs`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0.
  - All tags invalid, so `rsp_valid`=0.
  - Counters=0.
  - `req_ready`=0 while `rst` is high.
- Read accepted at edge E:
  - `mem_cs`=1 during cycle E..E+1.
  - RAM samples at E+1.
  - `rsp_valid`=1 during cycle E+1+RD_LATENCY .. E+2+RD_LATENCY.
  - Total latency is RD_LATENCY+1 edges.
- Write accepted at edge E: RAM writes at E+1. A read of the same address accepted at E+1 or later returns the new data.
- Reset asserted mid-operation: all in-flight tags are dropped and no response is emitted for them. Late RAM data is ignored.
- Grant and a pointer update in the same cycle as a wrap from N_REQ-1 to 0 is legal.

## Structure
- Package `spram_arb_pkg`: `rd_tag_t` struct {valid, id}, counter width constant `CNT_W`=16, and the saturating-increment function.
- Sub-module `rr_arbiter` (parameter N): inputs req/ptr, output one-hot grant and the granted index. It is reusable by other shared-resource blocks.
- Top level: command register, tag pipeline, counters.

## Test plan
- Single requester 1: write 0xA5@0x10, then read 0x10 with RD_LATENCY=1 → `mem_cs` one cycle per op; `rsp_valid` two edges after the read acceptance with id=1, data=0xA5.
- All 4 requesters hold valid reads for 8 cycles from reset → grants in order 0,1,2,3,0,1,2,3; responses carry the same id order.
- Requesters 3 and 0 only, ptr=3 → grant 3, then 0 (wrap), then 3; no cycle without a grant.
- RAM ecccorr injected on 3 reads and eccderr on 1 read → `corr_cnt`=3, `derr_cnt`=1. Preload `corr_cnt` near 0xFFFF via 65540 corrections → holds at 0xFFFF.
- RD_LATENCY=3, back-to-back reads from requesters 0,1,2 → three consecutive `rsp_valid` cycles, ids 0,1,2, first response 4 edges after the first acceptance.
- `rst` pulsed while two reads are in flight → no `rsp_valid` afterwards, `ptr`=0, first grant after reset goes to the lowest valid requester.
